fpu_add_retire_pipe: RTL and testbench

//  Retirement and exception pipeline for an NCH-channel FP add/sub/compare/permute unit.

---
 rtl/fpu_add_retire_pipe.sv | 110 +++++++++++
 tb/tb_fpu_add_retire_pipe.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fpu_add_retire_pipe.sv
// fpu_add_retire_pipe: retire/exception pipeline carrying return tags beside an NCH-channel FP add datapath
// Ports: clk/rst (async high); flush kills in-flight issued ops; iss_en/iss_ret issue per channel;
// iss_rdy back-pressure on XCH; xdata_en/xdata_ret inject on XCH; cmp_vld asks for res_raise;
// fpcsr_en trap enables; flg_clr clears sticky flags; ret_* registered completions;
// excpt_* lowest trapping channel/flag; flg_acc sticky flags; collide sticky issue/xdata clash.
module fpu_add_retire_pipe #(
  parameter int NCH  = 3,
  parameter int LAT  = 4,
  parameter int RETW = 14,
  parameter int FLGW = 11,
  parameter int XCH  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [NCH-1:0]      iss_en,
  input  logic [NCH*RETW-1:0] iss_ret,
  output logic [NCH-1:0]      iss_rdy,
  input  logic                xdata_en,
  input  logic [RETW-1:0]     xdata_ret,
  output logic [NCH-1:0]      cmp_vld,
  input  logic [NCH*FLGW-1:0] res_raise,
  input  logic [FLGW-1:0]     fpcsr_en,
  input  logic                flg_clr,
  output logic [NCH-1:0]      ret_vld,
  output logic [NCH*RETW-1:0] ret_tag,
  output logic [NCH-1:0]      ret_xd,
  output logic                excpt_en,
  output logic [1:0]          excpt_ch,
  output logic [3:0]          excpt_no,
  output logic [FLGW-1:0]     flg_acc,
  output logic                collide
);
  logic [LAT-1:0][NCH-1:0]           r_v, r_x;
  logic [LAT-1:0][NCH-1:0][RETW-1:0] r_t;
  logic [NCH-1:0][FLGW-1:0]          r_r;
  logic [NCH-1:0]                    w_xin, w_in_v, w_rt, w_rx;
  logic [NCH-1:0][RETW-1:0]          w_in_t;
  logic [NCH-1:0][FLGW-1:0]          w_trap;
  logic [FLGW-1:0]                   w_racc;
  logic                              w_en;
  logic [1:0]                        w_ch;
  logic [3:0]                        w_no;
  // xdata wins channel XCH; flushed issues never enter the pipe
  always_comb begin
    w_xin = '0;
    w_xin[XCH] = xdata_en;
    w_in_v = (iss_en & ~w_xin & {NCH{~flush}}) | w_xin;
    w_in_t = iss_ret;
    w_in_t[XCH] = xdata_en ? xdata_ret : iss_ret[XCH*RETW +: RETW];
  end
  assign iss_rdy = ~w_xin;
  assign cmp_vld = r_v[LAT-2] & ~r_x[LAT-2];
  assign w_rt    = r_v[LAT-1] & ~r_x[LAT-1] & {NCH{~flush}};
  assign w_rx    = r_v[LAT-1] & r_x[LAT-1];
  // descending scan so the lowest trapping channel and lowest flag bit win
  always_comb begin
    w_trap = '0;
    w_racc = '0;
    w_en = 1'b0;
    w_ch = '0;
    w_no = '0;
    for (int c = NCH-1; c >= 0; c--) begin
      w_trap[c] = w_rt[c] ? r_r[c] & fpcsr_en : '0;
      w_racc = w_racc | (w_rt[c] ? r_r[c] : '0);
      if (|w_trap[c]) begin
        w_en = 1'b1;
        w_ch = 2'(c);
        for (int b = FLGW-1; b >= 0; b--) if (w_trap[c][b]) w_no = 4'(b);
      end
    end
  end
  // raise is captured as the op enters the last stage, then judged at its retire edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      r_x <= '0;
      r_t <= '0;
      r_r <= '0;
      ret_vld <= '0;
      ret_tag <= '0;
      ret_xd <= '0;
      excpt_en <= 1'b0;
      excpt_ch <= '0;
      excpt_no <= '0;
      flg_acc <= '0;
      collide <= 1'b0;
    end else begin
      r_v[0] <= w_in_v;
      r_x[0] <= w_xin;
      r_t[0] <= w_in_t;
      for (int s = 1; s < LAT; s++) begin
        r_v[s] <= r_v[s-1] & (r_x[s-1] | {NCH{~flush}});
        r_x[s] <= r_x[s-1];
        r_t[s] <= r_t[s-1];
      end
      for (int c = 0; c < NCH; c++) begin
        r_r[c] <= cmp_vld[c] ? res_raise[c*FLGW +: FLGW] : '0;
        ret_tag[c*RETW +: RETW] <= (w_rt[c] | w_rx[c]) ? r_t[LAT-1][c] : '0;
      end
      ret_vld <= w_rt | w_rx;
      ret_xd <= w_rx;
      excpt_en <= w_en;
      excpt_ch <= w_ch;
      excpt_no <= w_no;
      flg_acc <= (flg_clr ? '0 : flg_acc) | w_racc;
      collide <= collide | (iss_en[XCH] & xdata_en);
    end
  end
endmodule

// File: tb/tb_fpu_add_retire_pipe.sv
// tb_fpu_add_retire_pipe: directed self-checking bench for fpu_add_retire_pipe
module tb_fpu_add_retire_pipe;
  localparam int NCH = 3, LAT = 4, RETW = 14, FLGW = 11, XCH = 2;
  logic                clk, rst, flush, xdata_en, flg_clr;
  logic [NCH-1:0]      iss_en, iss_rdy, cmp_vld, ret_vld, ret_xd;
  logic [NCH*RETW-1:0] iss_ret, ret_tag;
  logic [RETW-1:0]     xdata_ret;
  logic [NCH*FLGW-1:0] res_raise;
  logic [FLGW-1:0]     fpcsr_en, flg_acc;
  logic                excpt_en, collide;
  logic [1:0]          excpt_ch;
  logic [3:0]          excpt_no;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  fpu_add_retire_pipe #(.NCH(NCH), .LAT(LAT), .RETW(RETW), .FLGW(FLGW), .XCH(XCH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .iss_en(iss_en), .iss_ret(iss_ret), .iss_rdy(iss_rdy),
    .xdata_en(xdata_en), .xdata_ret(xdata_ret), .cmp_vld(cmp_vld), .res_raise(res_raise),
    .fpcsr_en(fpcsr_en), .flg_clr(flg_clr), .ret_vld(ret_vld), .ret_tag(ret_tag), .ret_xd(ret_xd),
    .excpt_en(excpt_en), .excpt_ch(excpt_ch), .excpt_no(excpt_no), .flg_acc(flg_acc), .collide(collide)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [NCH*RETW-1:0] exp_tag;
    rst = 1'b1; flush = 0; iss_en = 0; iss_ret = 0; xdata_en = 0; xdata_ret = 0;
    res_raise = 0; fpcsr_en = 11'h014; flg_clr = 0;
    #1;
    chk("rst ret_vld", 64'(ret_vld), 0);
    chk("rst flg_acc", 64'(flg_acc), 0);
    chk("rst collide", 64'(collide), 0);
    chk("rst iss_rdy", 64'(iss_rdy), 3'b111);
    tick(); tick();
    rst = 1'b0;
    tick();
    iss_en = 3'b001; iss_ret = 0; iss_ret[0 +: RETW] = 14'h0123;
    tick();
    iss_en = 0; iss_ret = 0;
    for (int k = 1; k < LAT; k++) begin
      chk("t1 early ret", 64'(ret_vld), 0);
      chk("t1 cmp_vld", 64'(cmp_vld), (k == LAT-1) ? 64'h1 : 64'h0);
      tick();
    end
    chk("t1 pre ret", 64'(ret_vld), 0);
    tick();
    chk("t1 ret_vld", 64'(ret_vld), 3'b001);
    chk("t1 ret_tag", 64'(ret_tag), 64'h0123);
    chk("t1 excpt_en", 64'(excpt_en), 0);
    tick();
    chk("t1 one pulse", 64'(ret_vld), 0);
    chk("t1 tag zero", 64'(ret_tag), 0);
    for (int n = 0; n < LAT + 11; n++) begin
      iss_en = (n < 10) ? 3'b111 : 3'b000;
      iss_ret = 0;
      if (n < 10) iss_ret = {14'(3*n+3), 14'(3*n+2), 14'(3*n+1)};
      tick();
      if (n >= LAT && n < LAT + 10) begin
        exp_tag = {14'(3*(n-LAT)+3), 14'(3*(n-LAT)+2), 14'(3*(n-LAT)+1)};
        chk("t2 ret_vld", 64'(ret_vld), 3'b111);
        chk("t2 ret_tag", 64'(ret_tag), 64'(exp_tag));
      end
    end
    iss_en = 0; iss_ret = 0;
    chk("t2 drained", 64'(ret_vld), 0);
    chk("t2 flg_acc", 64'(flg_acc), 0);
    iss_en = 3'b110; iss_ret = {14'h0222, 14'h0111, 14'h0000};
    tick();
    iss_en = 0; iss_ret = 0;
    repeat (LAT-2) tick();
    chk("t3 cmp_vld", 64'(cmp_vld), 3'b110);
    res_raise = {11'h010, 11'h004, 11'h000};
    tick();
    res_raise = 0;
    tick();
    chk("t3 ret_vld", 64'(ret_vld), 3'b110);
    chk("t3 excpt_en", 64'(excpt_en), 1);
    chk("t3 excpt_ch", 64'(excpt_ch), 1);
    chk("t3 excpt_no", 64'(excpt_no), 2);
    chk("t3 flg_acc", 64'(flg_acc), 11'h014);
    tick();
    chk("t3 excpt pulse", 64'(excpt_en), 0);
    chk("t3 excpt_no clr", 64'(excpt_no), 0);
    res_raise = '1;
    xdata_en = 1; xdata_ret = 14'h3FFF; iss_en = 3'b100; iss_ret = {14'h0AAA, 28'h0};
    #1;
    chk("t4 iss_rdy", 64'(iss_rdy), 3'b011);
    tick();
    xdata_en = 0; xdata_ret = 0; iss_en = 0; iss_ret = 0;
    chk("t4 collide", 64'(collide), 1);
    repeat (LAT-2) tick();
    chk("t4 no cmp_vld", 64'(cmp_vld), 0);
    tick(); tick();
    chk("t4 ret_vld", 64'(ret_vld), 3'b100);
    chk("t4 ret_xd", 64'(ret_xd), 3'b100);
    chk("t4 ret_tag", 64'(ret_tag), {14'h3FFF, 28'h0});
    chk("t4 no trap", 64'(excpt_en), 0);
    tick();
    res_raise = 0;
    chk("t4 dropped op", 64'(ret_vld), 0);
    chk("t4 flg_acc", 64'(flg_acc), 11'h014);
    iss_en = 3'b001; iss_ret = 42'h11; xdata_en = 1; xdata_ret = 14'h0222;
    tick();
    iss_ret = 42'h12; xdata_en = 0; xdata_ret = 0;
    tick();
    iss_en = 0; iss_ret = 0; flush = 1;
    tick();
    flush = 0;
    chk("t5 after flush", 64'(ret_vld), 0);
    tick();
    chk("t5 t+3", 64'(ret_vld), 0);
    tick();
    chk("t5 xd ret_vld", 64'(ret_vld), 3'b100);
    chk("t5 xd ret_xd", 64'(ret_xd), 3'b100);
    chk("t5 xd ret_tag", 64'(ret_tag), {14'h0222, 28'h0});
    tick();
    chk("t5 killed op", 64'(ret_vld), 0);
    chk("t5 collide sticky", 64'(collide), 1);
    iss_en = 3'b111; iss_ret = {14'h7, 14'h6, 14'h5};
    tick();
    iss_ret = {14'h8, 14'h9, 14'hA};
    tick();
    iss_en = 0; iss_ret = 0;
    repeat (LAT-1) tick();
    chk("t6 pre-rst ret", 64'(ret_vld), 3'b111);
    #1 rst = 1;
    #1;
    chk("t6 async ret_vld", 64'(ret_vld), 0);
    chk("t6 async ret_tag", 64'(ret_tag), 0);
    chk("t6 async flg_acc", 64'(flg_acc), 0);
    chk("t6 async collide", 64'(collide), 0);
    tick();
    rst = 0;
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      chk("t6 no ret after rst", 64'(ret_vld), 0);
    end
    iss_en = 3'b001; iss_ret = 42'h21;
    tick();
    iss_en = 3'b010; iss_ret = {14'h0, 14'h22, 14'h0};
    tick();
    iss_en = 0; iss_ret = 0;
    repeat (LAT-3) tick();
    res_raise = {22'h0, 11'h002};
    tick();
    res_raise = {11'h0, 11'h001, 11'h0};
    tick();
    res_raise = 0;
    chk("t6 flg_acc set", 64'(flg_acc), 11'h002);
    flg_clr = 1;
    tick();
    flg_clr = 0;
    chk("t6 clr ret_vld", 64'(ret_vld), 3'b010);
    chk("t6 clr+set", 64'(flg_acc), 11'h001);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
